// File: rtl/player_hit_detector_pkg.sv
// Shared constants, FSM state encoding and mask helpers for the player hit detector.
// The state encoding is shared with the game-control FSM.
package player_hit_detector_pkg;

   localparam int PROJ_WIDTH_SCALED    = 6;
   localparam int PROJ_HEIGHT_SCALED   = 12;
   localparam int PLAYER_WIDTH_SCALED  = 26;
   localparam int PLAYER_HEIGHT_SCALED = 16;

   localparam int POS_W = 10;
   localparam int CMP_W = POS_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHK1   = 3'd1,
      ST_CHK2   = 3'd2,
      ST_CHK3   = 3'd3,
      ST_REPORT = 3'd4
   } phd_state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } pos_t;

   function automatic logic [3:1] lowest_onehot(input logic [3:1] mask);
      logic [3:1] onehot;
      onehot = 3'b000;
      if (mask[1])      onehot = 3'b001;
      else if (mask[2]) onehot = 3'b010;
      else if (mask[3]) onehot = 3'b100;
      return onehot;
   endfunction

   function automatic logic [1:0] lowest_code(input logic [3:1] mask);
      logic [1:0] code;
      code = 2'd0;
      if (mask[1])      code = 2'd1;
      else if (mask[2]) code = 2'd2;
      else if (mask[3]) code = 2'd3;
      return code;
   endfunction

endpackage

// File: rtl/player_hit_detector_box_overlap.sv
// Combinational axis-aligned box overlap test on 11-bit unsigned operands.
// Box A is at (i_ax,i_ay) with size AW x AH, box B at (i_bx,i_by) with size BW x BH.
module box_overlap
   import player_hit_detector_pkg::*;
#(
   parameter int AW = PROJ_WIDTH_SCALED,
   parameter int AH = PROJ_HEIGHT_SCALED,
   parameter int BW = PLAYER_WIDTH_SCALED,
   parameter int BH = PLAYER_HEIGHT_SCALED
) (
   input  logic [CMP_W-1:0] i_ax,
   input  logic [CMP_W-1:0] i_ay,
   input  logic [CMP_W-1:0] i_bx,
   input  logic [CMP_W-1:0] i_by,
   output logic             o_overlap
);

   localparam logic [CMP_W-1:0] C_AW = CMP_W'(AW);
   localparam logic [CMP_W-1:0] C_AH = CMP_W'(AH);
   localparam logic [CMP_W-1:0] C_BW = CMP_W'(BW);
   localparam logic [CMP_W-1:0] C_BH = CMP_W'(BH);

   logic [CMP_W-1:0] w_a_right;
   logic [CMP_W-1:0] w_a_bottom;
   logic [CMP_W-1:0] w_b_right;
   logic [CMP_W-1:0] w_b_bottom;

   // Strict compares: boxes that only share an edge do not overlap.
   assign w_a_right  = i_ax + C_AW;
   assign w_a_bottom = i_ay + C_AH;
   assign w_b_right  = i_bx + C_BW;
   assign w_b_bottom = i_by + C_BH;

   assign o_overlap = (i_ax < w_b_right) && (i_bx < w_a_right) &&
                      (i_ay < w_b_bottom) && (i_by < w_a_bottom);

endmodule

// File: rtl/player_hit_detector.sv
// Per-frame check of three invader missiles against the player box; emits collision codes,
// owns lives and game_over. Optional feature macro: PLAYER_INVINCIBILITY_EN.
module player_hit_detector
   import player_hit_detector_pkg::*;
#(
   parameter int PLAYER_W   = PLAYER_WIDTH_SCALED,
   parameter int PLAYER_H   = PLAYER_HEIGHT_SCALED,
   parameter int MISSILE_W  = PROJ_WIDTH_SCALED,
   parameter int MISSILE_H  = PROJ_HEIGHT_SCALED,
   parameter int LIVES_INIT = 3
`ifdef PLAYER_INVINCIBILITY_EN
   ,
   parameter int INV_FRAMES = 60
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_frame,
   input  logic [POS_W-1:0] i_player_x,
   input  logic [POS_W-1:0] i_player_y,
   input  logic [POS_W-1:0] i_m1_x,
   input  logic [POS_W-1:0] i_m1_y,
   input  logic [POS_W-1:0] i_m2_x,
   input  logic [POS_W-1:0] i_m2_y,
   input  logic [POS_W-1:0] i_m3_x,
   input  logic [POS_W-1:0] i_m3_y,
   output logic [1:0]       o_player_collision,
   output logic             o_hit,
   output logic [1:0]       o_lives,
   output logic             o_game_over,
   output logic             o_busy
);

   phd_state_t r_state;
   phd_state_t w_next_state;

   pos_t       r_snap_p;
   pos_t       r_snap_m1;
   pos_t       r_snap_m2;
   pos_t       r_snap_m3;
   pos_t       w_msl;

   logic [3:1] r_mask;
   logic       r_rep_first;
   logic [1:0] r_collision;
   logic       r_hit;
   logic [1:0] r_lives;
   logic       r_game_over;

   logic       w_accept;
   logic       w_overlap;
   logic [3:1] w_onehot;
   logic [3:1] w_mask_rest;
   logic [1:0] w_code;
   logic       w_protected;
   logic       w_life_loss;

   assign w_accept    = (r_state == ST_IDLE) && i_frame;
   assign w_onehot    = lowest_onehot(r_mask);
   assign w_code      = lowest_code(r_mask);
   assign w_mask_rest = r_mask & ~w_onehot;

   // NOTE: the snapshot is always written on frame acceptance before any CHK state reads it,
   // so it carries no reset; only control state is reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_snap_p  <= '{x: i_player_x, y: i_player_y};
         r_snap_m1 <= '{x: i_m1_x, y: i_m1_y};
         r_snap_m2 <= '{x: i_m2_x, y: i_m2_y};
         r_snap_m3 <= '{x: i_m3_x, y: i_m3_y};
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_msl = r_snap_m1;
      case (r_state)
         ST_CHK2: w_msl = r_snap_m2;
         ST_CHK3: w_msl = r_snap_m3;
         default: w_msl = r_snap_m1;
      endcase
   end

   box_overlap #(
      .AW (MISSILE_W),
      .AH (MISSILE_H),
      .BW (PLAYER_W),
      .BH (PLAYER_H)
   ) u_box_overlap (
      .i_ax      ({1'b0, w_msl.x}),
      .i_ay      ({1'b0, w_msl.y}),
      .i_bx      ({1'b0, r_snap_p.x}),
      .i_by      ({1'b0, r_snap_p.y}),
      .o_overlap (w_overlap)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (i_frame) w_next_state = ST_CHK1;
         ST_CHK1:   w_next_state = ST_CHK2;
         ST_CHK2:   w_next_state = ST_CHK3;
         ST_CHK3:   w_next_state = ST_REPORT;
         ST_REPORT: if (w_mask_rest == 3'b000) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // A life is charged once per frame, on the first REPORT cycle only.
   assign w_life_loss = (r_state == ST_REPORT) && r_rep_first && (r_mask != 3'b000) &&
                        (r_lives != 2'd0) && !w_protected;

`ifdef PLAYER_INVINCIBILITY_EN
   localparam int INV_W = $clog2(INV_FRAMES + 1);

   logic [INV_W-1:0] r_inv_cnt;
   logic             r_inv_active;

   // Protection for a frame is decided from the count seen when that frame is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv_cnt    <= '0;
         r_inv_active <= 1'b0;
      end else if (w_accept) begin
         r_inv_active <= (r_inv_cnt != '0);
         if (r_inv_cnt != '0) r_inv_cnt <= r_inv_cnt - 1'b1;
      end else if (w_life_loss) begin
         r_inv_cnt <= INV_W'(INV_FRAMES);
      end
   end

   assign w_protected = r_inv_active;
`else
   assign w_protected = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mask      <= 3'b000;
         r_rep_first <= 1'b0;
         r_collision <= 2'd0;
         r_hit       <= 1'b0;
         r_lives     <= 2'(LIVES_INIT);
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_collision <= 2'd0;
         r_hit       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_frame) begin
                  r_mask      <= 3'b000;
                  r_rep_first <= 1'b1;
               end
            end
            ST_CHK1: r_mask[1] <= w_overlap;
            ST_CHK2: r_mask[2] <= w_overlap;
            ST_CHK3: r_mask[3] <= w_overlap;
            ST_REPORT: begin
               r_rep_first <= 1'b0;
               if (r_mask != 3'b000) begin
                  r_collision <= w_code;
                  r_mask      <= w_mask_rest;
               end
               if (w_life_loss) begin
                  r_hit   <= 1'b1;
                  r_lives <= r_lives - 2'd1;
                  if (r_lives == 2'd1) r_game_over <= 1'b1;
               end
            end
            default: r_mask <= 3'b000;
         endcase
      end
   end

   assign o_player_collision = r_collision;
   assign o_hit              = r_hit;
   assign o_lives            = r_lives;
   assign o_game_over        = r_game_over;
   assign o_busy             = (r_state != ST_IDLE);

endmodule
